prio_load_sequencer: RTL
========================

Name: prio_load_sequencer

Overview:
- Drives a downstream loadable register with a stream of priority-ordered load commands.
- Takes three asynchronous request lines (A highest, B, C lowest) plus a data stream, and serializes them into one valid/ready output channel.
- Each output beat carries either a fixed preset value or a data word, plus a source tag, so a synchronous consumer can apply them in priority order.

Parameters:
- W, 2, width of data and output value.
- VAL_A, 2, value emitted for an A event.
- VAL_B, 1, value emitted for a B event.
- VAL_C, 0, value emitted for a C event.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_a  in  1  async request A, highest priority.
- req_b  in  1  async request B.
- req_c  in  1  async request C, lowest event priority.
- d_in  in  W  data word.
- d_valid  in  1  data word offered.
- d_ready  out  1  data word accepted when d_valid & d_ready.
- q  out  W  output value.
- q_src  out  2  source tag: 3=A, 2=B, 1=C, 0=data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat when out_valid & out_ready.

Behaviour:
- Reset (sync, rst=1 at clk edge): sync flops, edge history, pending[2:0], out_valid, q and q_src all go to 0. d_ready is 0 while rst=1.
- Synchronizer: each req_x passes through 2 flops, then a third history flop. rise_x = sync2 & ~hist.
- Edge timing: req_x rises before edge k. sync2 is high after edge k+1. pending_x is set at edge k+2.
- Pending set/clear: pending_x is set on rise_x. It is cleared when selected. If set and clear fall in the same cycle, set wins and the event stays pending once more.
- Lost event: rise_x while pending_x=1 and pending_x is not being cleared that cycle. The event is dropped, as it is already pending.
- Output slot free: slot_free = ~out_valid | out_ready.
- Selection when slot_free:
  - pending_a gives q=VAL_A, src=3.
  - else pending_b gives q=VAL_B, src=2.
  - else pending_c gives q=VAL_C, src=1.
  - else d_valid gives q=d_in, src=0.
  - Whatever is selected is loaded into q/q_src at the edge, with out_valid=1.
- Latency: pending set at edge k+2 gives out_valid at edge k+3 if the slot is free.
- d_ready = slot_free & ~|pending, combinational. Events always pre-empt data.
- If slot_free and nothing is selectable, out_valid goes to 0 at the edge.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1 and out_ready=0. q, q_src and out_valid are held stable and no new load occurs.
  - HOLD & out_ready: back-to-back reload is allowed, one beat per cycle.
- Requests held high produce one event only. A new event needs a low then high transition, with at least 1 low cycle after sync.
- Reset mid-operation: everything above clears, including pending events and the beat in flight. There is no replay.
- Arithmetic: none beyond the width-W mux. VAL_x are truncated to W.

Optional Feature:
- Macro: PLS_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0]. It increments by 1 per lost event. If two or three sources lose an event in the same cycle, it increments by their sum. It saturates at 255 and is cleared by rst.
- Undefined: no port and no counter logic. Lost events are silently discarded.

Test Plan:
- Reset, then pulse req_b for 3 cycles with out_ready=1:
  - out_valid=1, q=1, q_src=2 exactly 3 edges after req_b is first sampled high;
  - one beat only.
- Raise req_a, req_b and req_c in the same cycle with out_ready=1:
  - beats on 3 consecutive cycles: (2,3), (1,2), (0,1);
  - d_ready=0 throughout.
- d_valid=1 with d_in=3, out_ready=0 for 4 cycles, then 1:
  - first beat q=3, src=0 is held 4 cycles;
  - d_ready=0 during the hold;
  - one transfer per ready cycle afterwards.
- While out_ready=0 holds beat (3,0), raise req_c:
  - the held beat is unchanged;
  - on release, the next beat is (0,1) before further data.
- Two req_a pulses, each 2 cycles high and 2 low, while out_ready=0 for 20 cycles:
  - only one A beat is emitted;
  - with PLS_DROP_CNT_EN, drop_cnt=1.
- Assert rst while pending_a=1 and out_valid=1:
  - the next cycle has out_valid=0 and pending cleared;
  - no A beat appears after reset.

Source files
------------

// File: rtl/prio_load_sequencer.sv
// Serializes three async edge requests (A>B>C) and a data stream onto one valid/ready channel.
// Optional PLS_DROP_CNT_EN adds a saturating count of requests lost while already pending.
module prio_load_sequencer #(
  parameter int W     = 2,
  parameter int VAL_A = 2,
  parameter int VAL_B = 1,
  parameter int VAL_C = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic         req_b,
  input  logic         req_c,
  input  logic [W-1:0] d_in,
  input  logic         d_valid,
  output logic         d_ready,
  output logic [W-1:0] q,
  output logic [1:0]   q_src,
  output logic         out_valid,
`ifdef PLS_DROP_CNT_EN
  output logic [7:0]   drop_cnt,
`endif
  input  logic         out_ready
);

  localparam logic [W-1:0] VA = W'(VAL_A);
  localparam logic [W-1:0] VB = W'(VAL_B);
  localparam logic [W-1:0] VC = W'(VAL_C);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t       state_q;
  logic [2:0]   s1_q, s2_q, hist_q;
  logic [2:0]   pend_q, pend_d;
  logic [2:0]   rise, clr, lost;
  logic [W-1:0] q_q, ld_q;
  logic [1:0]   src_q, ld_src;
  logic         ld, slot_free;

  // Bit 2 is A, bit 1 is B, bit 0 is C throughout.
  assign rise      = s2_q & ~hist_q;
  assign slot_free = (state_q == S_IDLE) | out_ready;

  always_comb begin
    clr    = 3'b000;
    ld     = 1'b0;
    ld_q   = d_in;
    ld_src = 2'd0;
    if (slot_free) begin
      if (pend_q[2]) begin
        clr = 3'b100; ld = 1'b1; ld_q = VA; ld_src = 2'd3;
      end else if (pend_q[1]) begin
        clr = 3'b010; ld = 1'b1; ld_q = VB; ld_src = 2'd2;
      end else if (pend_q[0]) begin
        clr = 3'b001; ld = 1'b1; ld_q = VC; ld_src = 2'd1;
      end else if (d_valid) begin
        ld = 1'b1;
      end
    end
  end

  // A fresh edge beats a same-cycle clear, so the event is served again.
  assign pend_d = (pend_q & ~clr) | rise;
  assign lost   = rise & pend_q & ~clr;

  assign d_ready   = ~rst & slot_free & ~|pend_q;
  assign q         = q_q;
  assign q_src     = src_q;
  assign out_valid = (state_q == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      q_q     <= '0;
      src_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      s1_q   <= {req_a, req_b, req_c};
      s2_q   <= s1_q;
      hist_q <= s2_q;
      pend_q <= pend_d;
      if (slot_free) begin
        if (ld) begin
          q_q     <= ld_q;
          src_q   <= ld_src;
          state_q <= S_HOLD;
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  end

`ifdef PLS_DROP_CNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + 9'(lost[0]) + 9'(lost[1])
                 + 9'(lost[2]);
  assign cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  assign drop_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_lost;
  assign unused_lost = ^lost;
`endif

endmodule
